// File: rtl/aes_pkg.sv
// Shared AES constants, state encoding, S-box and round-constant helpers.
package aes_pkg;

  localparam int unsigned AES_NR = 10;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned KEY_W  = 128;
  localparam int unsigned CTR_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    EMIT = 2'd2
  } ks_state_e;

  // Forward AES S-box as a constant lookup.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s;
    s = 8'h00;
    case (a)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
    endcase
    return s;
  endfunction

  // Round constant for schedule step i (1..10), placed in the top byte.
  function automatic logic [31:0] rcon(input logic [3:0] i);
    logic [31:0] r;
    r = 32'h0000_0000;
    case (i)
      4'd1:    r = 32'h0100_0000;
      4'd2:    r = 32'h0200_0000;
      4'd3:    r = 32'h0400_0000;
      4'd4:    r = 32'h0800_0000;
      4'd5:    r = 32'h1000_0000;
      4'd6:    r = 32'h2000_0000;
      4'd7:    r = 32'h4000_0000;
      4'd8:    r = 32'h8000_0000;
      4'd9:    r = 32'h1b00_0000;
      4'd10:   r = 32'h3600_0000;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_subword_rot.sv
// Combinational SubWord(RotWord(w)): rotate left one byte, then S-box each byte.
module aes_subword_rot
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] w,
  output logic [WORD_W-1:0] sw_c
);

  logic [WORD_W-1:0] rot;

  assign rot = {w[23:0], w[31:24]};

  // Four byte lanes share the package S-box table.
  assign sw_c = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

endmodule

// File: rtl/aes_inv_key_sched_128.sv
// AES-128 key schedule that walks forward to round 10, then streams round
// keys 10..0 by undoing one schedule step per accepted key.
module aes_inv_key_sched_128
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KEY_W-1:0]  key,
  output logic              busy,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [KEY_W-1:0]  rk,
  output logic [CTR_W-1:0]  rk_round,
  output logic              done
);

  ks_state_e          state, state_nx;
  logic [KEY_W-1:0]   kreg, kreg_nx;
  logic [CTR_W-1:0]   ctr, ctr_nx;
  logic               done_nx;

  logic [WORD_W-1:0]  w0, w1, w2, w3;
  logic [WORD_W-1:0]  n0, n1, n2, n3;
  logic [WORD_W-1:0]  p0, p1, p2, p3;
  logic [WORD_W-1:0]  sub_in, sub_out, rc;

  assign w0 = kreg[127:96];
  assign w1 = kreg[95:64];
  assign w2 = kreg[63:32];
  assign w3 = kreg[31:0];

  // Inverse step recovers the previous round's w3 first; it feeds the S-box.
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  // One S-box word shared by both phases; rcon index differs per phase.
  assign sub_in = (state == EMIT) ? p3 : w3;
  assign rc     = rcon((state == EMIT) ? ctr : ctr + CTR_W'(1));

  aes_subword_rot u_subword_rot (
    .w    (sub_in),
    .sw_c (sub_out)
  );

  assign n0 = w0 ^ sub_out ^ rc;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign p0 = w0 ^ sub_out ^ rc;

  // Next-state and datapath update.
  always_comb begin
    state_nx = state;
    kreg_nx  = kreg;
    ctr_nx   = ctr;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          kreg_nx  = key;
          ctr_nx   = '0;
          state_nx = FWD;
        end
      end
      FWD: begin
        kreg_nx = {n0, n1, n2, n3};
        ctr_nx  = ctr + CTR_W'(1);
        if (ctr_nx == CTR_W'(AES_NR)) begin
          state_nx = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (ctr == '0) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            kreg_nx = {p0, p1, p2, p3};
            ctr_nx  = ctr - CTR_W'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      kreg     <= '0;
      ctr      <= '0;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      kreg     <= kreg_nx;
      ctr      <= ctr_nx;
      busy     <= (state_nx != IDLE);
      rk_valid <= (state_nx == EMIT);
      done     <= done_nx;
    end
  end

  assign rk       = kreg;
  assign rk_round = ctr;

endmodule

// File: doc/aes_inv_key_sched_128.md
# aes_inv_key_sched_128

Iterative AES-128 key schedule for the decryption datapath. Given the 128-bit cipher key, it runs the forward schedule to derive the round-10 key, then streams the round keys in reverse order (10 down to 0) over a valid/ready handshake, undoing one schedule step per cycle. It holds one round key in registers and shares a single 4-byte SubWord unit between the forward and inverse phases. It sits between the key input and the inverse-cipher round engine.

## Interface
- No parameters; fixed at AES-128 (Nk=4, Nr=10).
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset; synchronous and active-high
- start  in  1  one-cycle request; samples `key`; honoured only in IDLE
- key  in  128  cipher key; word w0 = key[127:96] … w3 = key[31:0]
- busy  out  1  high in FWD and EMIT
- rk_valid  out  1  `rk` / `rk_round` hold a valid round key
- rk_ready  in  1  consumer accepts the key when `rk_valid & rk_ready`
- rk  out  128  round key, same word packing as `key`
- rk_round  out  4  round index of `rk` (10..0)
- done  out  1  one-cycle pulse after round 0 is accepted

## Operation
- States: IDLE, FWD, EMIT. Registers: `kreg` [127:0], `ctr` [3:0].
- IDLE, start=1: kreg←key, ctr←0, go to FWD. start=0: hold.
- FWD, each cycle: kreg←fwd(kreg, rcon(ctr+1)), ctr←ctr+1. When ctr becomes 10, go to EMIT.
  - fwd: n0=w0^SubWord(RotWord(w3))^rcon; n1=w1^n0; n2=w2^n1; n3=w3^n2.
- EMIT: rk=kreg, rk_round=ctr, rk_valid=1.
  - Accept with ctr>0: kreg←inv(kreg, rcon(ctr)), ctr←ctr−1; stay in EMIT with rk_valid high (back-to-back).
  - inv: p3=w3^w2; p2=w2^w1; p1=w1^w0; p0=w0^SubWord(RotWord(p3))^rcon.
  - Accept with ctr==0: go to IDLE; done=1 on the following cycle.
  - No accept: kreg, ctr, rk and rk_round hold stable.
- rcon(i), i=1..10: 01,02,04,08,10,20,40,80,1b,36 in byte [31:24]; the other bytes are zero.
- SubWord input mux: w3 in FWD and p3 in EMIT. There is exactly one 4-byte S-box instance.
- start in FWD or EMIT is ignored; `key` is sampled only on the accepted start.
- rst=1 in any state: go to IDLE and clear all registers. Reset beats a simultaneous start. A reset mid-run aborts with no done pulse.

## Timing
- Reset values: busy=0, rk_valid=0, rk=0, rk_round=0, done=0.
- Start sampled at edge T: busy=1 from T+1; rk_valid=1 with rk_round=10 from T+11.
- With rk_ready held high: 11 consecutive keys on T+11..T+21; done=1 on T+22; busy=0 from T+22.
- A new start is accepted in the cycle that done is high (state is IDLE).
- rk_valid never drops in EMIT until round 0 is accepted. Once asserted, rk stays stable until accepted.
- Outputs come straight from registers/state; there is no combinational path from rk_ready to rk_valid.
- Critical path: one S-box plus three XOR levels per cycle.

## Structure
- `aes_pkg` holds:
  - the S-box function (256-entry constant case, not $readmemh, so it synthesises)
  - the `rcon(i)` function
  - state enum constants IDLE/FWD/EMIT
  - `AES_NR = 10`
- One sub-module, `aes_subword_rot`: 32-bit combinational RotWord+SubWord, built from four package S-box calls. It can be reused by the forward key expansion.
- The top module contains the FSM, `kreg`, `ctr` and the fwd/inv XOR networks.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 → rk_valid at T+11 with rk=d014f9a8c9ee2589e13f0cc8b6630ca6, round 10. Round 1 = a0fafe1788542cb123a339392a6c7605. Round 0 = the key. done at T+22.
- Same key, rk_ready random 30% → all 11 keys in order 10..0, each matching the combinational forward expansion. rk stays stable while stalled.
- start pulsed during FWD and during EMIT with a different key → ignored; the output sequence is unchanged.
- rst asserted at T+5 (FWD) and, separately, while stalled in EMIT at round 6 → next cycle all outputs are 0, IDLE, no done pulse. A fresh start then gives the correct sequence.
- start in the same cycle as done with key 000102030405060708090a0b0c0d0e0f → round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Key all-zero and key all-FF, compared against the reference-model expansion → every round key matches.
